// File: rtl/cam_capture_param_if.sv
// Sensor-side byte stream and pixel-side output stream of the camera capture block.
// master: the capture block; slave: the sensor/consumer side.
interface cam_capture_param_if #(
    parameter int unsigned PIX_W = 16,
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 9
);
    logic             vsync;
    logic             href;
    logic [7:0]       data;
    logic [PIX_W-1:0] pixel_data;
    logic             pixel_valid;
    logic [XW-1:0]    pixel_x;
    logic [YW-1:0]    pixel_y;
    logic             sof;
    logic             eol;

    modport master (
        input  vsync, href, data,
        output pixel_data, pixel_valid, pixel_x, pixel_y, sof, eol
    );

    modport slave (
        output vsync, href, data,
        input  pixel_data, pixel_valid, pixel_x, pixel_y, sof, eol
    );
endinterface

// File: rtl/cam_capture_param.sv
// DVP-style camera capture: assembles sensor bytes into pixels, tracks line/frame geometry,
// decimates, and flags malformed lines and frames.
module cam_capture_param #(
    parameter int unsigned BYTES_PER_PIX = 2,
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned SWAP_BYTES    = 0,
    parameter int unsigned SUBSAMPLE     = 1
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 capture_en,
    input  logic                 single_shot,
    cam_capture_param_if.master  cam,
    output logic                 line_err,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt,
    output logic                 busy
);
    localparam int unsigned PIX_W = 8 * BYTES_PER_PIX;
    localparam int unsigned XW    = $clog2(H_ACTIVE);
    localparam int unsigned YW    = $clog2(V_ACTIVE);
    // Internal counters must be able to hold the saturation values H_ACTIVE / V_ACTIVE.
    localparam int unsigned XCW   = $clog2(H_ACTIVE + 1);
    localparam int unsigned YCW   = $clog2(V_ACTIVE + 1);
    localparam int unsigned BW    = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam int unsigned SS_SH = $clog2(SUBSAMPLE);

    localparam logic [BW-1:0]  LAST_BYTE  = BW'(BYTES_PER_PIX - 1);
    localparam logic [XCW-1:0] X_MAX      = XCW'(H_ACTIVE);
    localparam logic [YCW-1:0] Y_MAX      = YCW'(V_ACTIVE);
    localparam logic [XCW-1:0] X_SUB_MASK = XCW'(SUBSAMPLE - 1);
    localparam logic [YCW-1:0] Y_SUB_MASK = YCW'(SUBSAMPLE - 1);

    typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

    state_e           state_q, state_d;
    logic             single_q, single_d;
    logic             shot_done_q, shot_done_d;
    logic             seen_vs_q, seen_vs_d;
    logic             href_q, href_d;
    logic [BW-1:0]    byte_q, byte_d;
    logic [XCW-1:0]   x_q, x_d;
    logic [YCW-1:0]   y_q, y_d;
    logic             overrun_q, overrun_d;
    logic             bad_q, bad_d;
    logic             first_q, first_d;
    logic [PIX_W-1:0] acc_q, acc_d;
    logic [PIX_W-1:0] pixel_data_q, pixel_data_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic [XW-1:0]    pixel_x_q, pixel_x_d;
    logic [YW-1:0]    pixel_y_q, pixel_y_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             line_err_q, line_err_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic [7:0]       sh;
    logic [PIX_W-1:0] ins;

    always_comb begin
        state_d       = state_q;
        single_d      = single_q;
        shot_done_d   = shot_done_q;
        seen_vs_d     = seen_vs_q;
        href_d        = href_q;
        byte_d        = byte_q;
        x_d           = x_q;
        y_d           = y_q;
        overrun_d     = overrun_q;
        bad_d         = bad_q;
        first_d       = first_q;
        acc_d         = acc_q;
        pixel_data_d  = pixel_data_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        frame_cnt_d   = frame_cnt_q;
        pixel_valid_d = 1'b0;
        sof_d         = 1'b0;
        eol_d         = 1'b0;
        line_err_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;

        // Bit position of the current byte inside the pixel word.
        sh  = (SWAP_BYTES != 0) ? 8'(8 * int'(byte_q))
                                : 8'(int'(PIX_W) - 8 - 8 * int'(byte_q));
        ins = (acc_q & ~(PIX_W'(8'hFF) << sh)) | (PIX_W'(cam.data) << sh);

        unique case (state_q)
            StIdle: begin
                // A finished single-shot stays parked until capture_en is dropped.
                if (!capture_en) begin
                    shot_done_d = 1'b0;
                end else if (!shot_done_q) begin
                    state_d   = StSync;
                    single_d  = single_shot;
                    seen_vs_d = 1'b0;
                end
            end

            StSync: begin
                if (!capture_en) begin
                    state_d = StIdle;
                end else if (cam.vsync) begin
                    seen_vs_d = 1'b1;
                end else if (seen_vs_q) begin
                    state_d   = StActive;
                    href_d    = 1'b0;
                    byte_d    = '0;
                    x_d       = '0;
                    y_d       = '0;
                    overrun_d = 1'b0;
                    bad_d     = 1'b0;
                    first_d   = 1'b1;
                end
            end

            StActive: begin
                if (cam.vsync) begin
                    if (y_q == Y_MAX && !bad_q) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    href_d    = 1'b0;
                    seen_vs_d = 1'b0;
                    if (single_q || !capture_en) begin
                        state_d     = StIdle;
                        shot_done_d = single_q;
                    end else begin
                        state_d = StSync;
                    end
                end else begin
                    href_d = cam.href;
                    if (cam.href) begin
                        acc_d = ins;
                        if (byte_q == LAST_BYTE) begin
                            byte_d = '0;
                            if (x_q < X_MAX && y_q < Y_MAX &&
                                (x_q & X_SUB_MASK) == '0 && (y_q & Y_SUB_MASK) == '0) begin
                                pixel_valid_d = 1'b1;
                                pixel_data_d  = ins;
                                pixel_x_d     = XW'(x_q >> SS_SH);
                                pixel_y_d     = YW'(y_q >> SS_SH);
                                sof_d         = first_q;
                                first_d       = 1'b0;
                            end
                            // Overrun is remembered separately because x saturates.
                            if (x_q < X_MAX) begin
                                x_d = x_q + 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            byte_d = byte_q + 1'b1;
                        end
                    end else if (href_q) begin
                        eol_d = 1'b1;
                        if (x_q != X_MAX || overrun_q) begin
                            line_err_d = 1'b1;
                            bad_d      = 1'b1;
                        end
                        if (y_q < Y_MAX) begin
                            y_d = y_q + 1'b1;
                        end else begin
                            bad_d = 1'b1;
                        end
                        x_d       = '0;
                        byte_d    = '0;
                        overrun_d = 1'b0;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            single_q      <= 1'b0;
            shot_done_q   <= 1'b0;
            seen_vs_q     <= 1'b0;
            href_q        <= 1'b0;
            byte_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            overrun_q     <= 1'b0;
            bad_q         <= 1'b0;
            first_q       <= 1'b0;
            acc_q         <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            line_err_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            single_q      <= single_d;
            shot_done_q   <= shot_done_d;
            seen_vs_q     <= seen_vs_d;
            href_q        <= href_d;
            byte_q        <= byte_d;
            x_q           <= x_d;
            y_q           <= y_d;
            overrun_q     <= overrun_d;
            bad_q         <= bad_d;
            first_q       <= first_d;
            acc_q         <= acc_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            line_err_q    <= line_err_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign cam.pixel_data  = pixel_data_q;
    assign cam.pixel_valid = pixel_valid_q;
    assign cam.pixel_x     = pixel_x_q;
    assign cam.pixel_y     = pixel_y_q;
    assign cam.sof         = sof_q;
    assign cam.eol         = eol_q;
    assign line_err        = line_err_q;
    assign frame_done      = frame_done_q;
    assign frame_err       = frame_err_q;
    assign frame_cnt       = frame_cnt_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_cam_capture_param.sv
// Scoreboard bench for cam_capture_param on a reduced 8x4 geometry: one instance with MSB-first
// full-rate capture, one with LSB-first 2x decimation, both fed from the same sensor stream.
module tb_cam_capture_param;
    localparam int unsigned H = 8;
    localparam int unsigned V = 4;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       capture_en = 1'b0;
    logic       single_shot = 1'b0;
    logic       vsync = 1'b1;
    logic       href = 1'b0;
    logic [7:0] data = 8'h00;

    logic        line_err_a, frame_done_a, frame_err_a, busy_a;
    logic        line_err_b, frame_done_b, frame_err_b, busy_b;
    logic [15:0] frame_cnt_a, frame_cnt_b;

    always #5 pclk = ~pclk;

    cam_capture_param_if #(.PIX_W(16), .XW(3), .YW(2)) ifa ();
    cam_capture_param_if #(.PIX_W(16), .XW(3), .YW(2)) ifb ();

    assign ifa.vsync = vsync;
    assign ifa.href  = href;
    assign ifa.data  = data;
    assign ifb.vsync = vsync;
    assign ifb.href  = href;
    assign ifb.data  = data;

    cam_capture_param #(
        .BYTES_PER_PIX(2), .H_ACTIVE(H), .V_ACTIVE(V), .SWAP_BYTES(0), .SUBSAMPLE(1)
    ) dut_a (
        .pclk(pclk), .rst(rst), .capture_en(capture_en), .single_shot(single_shot), .cam(ifa),
        .line_err(line_err_a), .frame_done(frame_done_a), .frame_err(frame_err_a),
        .frame_cnt(frame_cnt_a), .busy(busy_a)
    );

    cam_capture_param #(
        .BYTES_PER_PIX(2), .H_ACTIVE(H), .V_ACTIVE(V), .SWAP_BYTES(1), .SUBSAMPLE(2)
    ) dut_b (
        .pclk(pclk), .rst(rst), .capture_en(capture_en), .single_shot(single_shot), .cam(ifb),
        .line_err(line_err_b), .frame_done(frame_done_b), .frame_err(frame_err_b),
        .frame_cnt(frame_cnt_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  x;
        logic [1:0]  y;
        logic        sof;
    } pix_t;

    pix_t qa[$];
    pix_t qb[$];
    pix_t ea, ga, eb, gb;
    int   n_checks = 0;
    int   n_fail = 0;
    int   eol_a, lerr_a, done_a, ferr_a;
    int   eol_b, lerr_b, done_b, ferr_b;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every emitted pixel and tallies strobes.
    always @(negedge pclk) begin
        if (!rst) begin
            if (ifa.pixel_valid) begin
                n_checks++;
                ga = {ifa.pixel_data, ifa.pixel_x, ifa.pixel_y, ifa.sof};
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_pixel: unexpected pixel %h (%0d,%0d)", ga.d, ga.x, ga.y);
                end else begin
                    ea = qa.pop_front();
                    if (ga !== ea) begin
                        n_fail++;
                        $display("FAIL a_pixel: got d=%h x=%0d y=%0d sof=%0d, expected d=%h x=%0d y=%0d sof=%0d",
                                 ga.d, ga.x, ga.y, ga.sof, ea.d, ea.x, ea.y, ea.sof);
                    end
                end
            end
            if (ifb.pixel_valid) begin
                n_checks++;
                gb = {ifb.pixel_data, ifb.pixel_x, ifb.pixel_y, ifb.sof};
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_pixel: unexpected pixel %h (%0d,%0d)", gb.d, gb.x, gb.y);
                end else begin
                    eb = qb.pop_front();
                    if (gb !== eb) begin
                        n_fail++;
                        $display("FAIL b_pixel: got d=%h x=%0d y=%0d sof=%0d, expected d=%h x=%0d y=%0d sof=%0d",
                                 gb.d, gb.x, gb.y, gb.sof, eb.d, eb.x, eb.y, eb.sof);
                    end
                end
            end
            if (ifa.eol)     eol_a++;
            if (line_err_a)  lerr_a++;
            if (frame_done_a) done_a++;
            if (frame_err_a) ferr_a++;
            if (ifb.eol)     eol_b++;
            if (line_err_b)  lerr_b++;
            if (frame_done_b) done_b++;
            if (frame_err_b) ferr_b++;
        end
    end

    // One frame: blanking low, nlines lines of H pixels (line bad_line carries bad_px pixels
    // plus odd stray bytes), then vsync high with ignored href activity during blanking.
    task automatic send_frame(input int nlines, input int bad_line, input int bad_px,
                              input int odd, input bit cap, input int rst_line,
                              input int cen_off_line, input logic [7:0] seed);
        logic [7:0] b0, b1;
        logic [7:0] bt;
        bit         live;
        bit         first_a, first_b;
        int         npx;
        bt = seed;
        live = cap;
        first_a = 1'b1;
        first_b = 1'b1;
        eol_a = 0; lerr_a = 0; done_a = 0; ferr_a = 0;
        eol_b = 0; lerr_b = 0; done_b = 0; ferr_b = 0;
        vsync = 1'b0;
        href = 1'b0;
        tick();
        tick();
        for (int l = 0; l < nlines; l++) begin
            if (l == cen_off_line) capture_en = 1'b0;
            if (l == rst_line) begin
                rst = 1'b1;
                #1;
                check("rst_busy", 32'(busy_a), 0);
                check("rst_frame_cnt", 32'(frame_cnt_a), 0);
                check("rst_pixel_data", 32'(ifa.pixel_data), 0);
                check("rst_pixel_valid", 32'(ifa.pixel_valid), 0);
                live = 1'b0;
                tick();
                rst = 1'b0;
            end
            npx = (l == bad_line) ? bad_px : int'(H);
            for (int p = 0; p < npx; p++) begin
                b0 = bt;
                bt = bt + 8'd1;
                b1 = bt;
                bt = bt + 8'd1;
                href = 1'b1;
                data = b0;
                tick();
                data = b1;
                tick();
                if (live && l < int'(V) && p < int'(H)) begin
                    qa.push_back({b0, b1, 3'(p), 2'(l), first_a});
                    first_a = 1'b0;
                    if (p % 2 == 0 && l % 2 == 0) begin
                        qb.push_back({b1, b0, 3'(p / 2), 2'(l / 2), first_b});
                        first_b = 1'b0;
                    end
                end
            end
            if (l == bad_line) begin
                for (int k = 0; k < odd; k++) begin
                    href = 1'b1;
                    data = bt;
                    bt = bt + 8'd1;
                    tick();
                end
            end
            href = 1'b0;
            repeat (3) tick();
        end
        vsync = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            href = 1'b1;
            data = bt;
            bt = bt + 8'd1;
            tick();
        end
        href = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_counts(input string tag, input int e_eol, input int e_lerr,
                                input int e_done, input int e_ferr, input int e_cnt);
        check({tag, "_a_eol"}, eol_a, e_eol);
        check({tag, "_a_line_err"}, lerr_a, e_lerr);
        check({tag, "_a_frame_done"}, done_a, e_done);
        check({tag, "_a_frame_err"}, ferr_a, e_ferr);
        check({tag, "_a_frame_cnt"}, 32'(frame_cnt_a), e_cnt);
        check({tag, "_b_eol"}, eol_b, e_eol);
        check({tag, "_b_line_err"}, lerr_b, e_lerr);
        check({tag, "_b_frame_done"}, done_b, e_done);
        check({tag, "_b_frame_err"}, ferr_b, e_ferr);
        check({tag, "_b_frame_cnt"}, 32'(frame_cnt_b), e_cnt);
    endtask

    initial begin
        repeat (3) tick();
        check("reset_pixel_valid", 32'(ifa.pixel_valid), 0);
        check("reset_pixel_data", 32'(ifa.pixel_data), 0);
        check("reset_frame_cnt", 32'(frame_cnt_a), 0);
        check("reset_busy", 32'(busy_a), 0);
        rst = 1'b0;
        tick();

        // Continuous capture, one clean frame.
        capture_en = 1'b1;
        repeat (3) tick();
        check("armed_busy", 32'(busy_a), 1);
        send_frame(4, -1, 0, 0, 1'b1, -1, -1, 8'h10);
        check_counts("good", 4, 0, 1, 0, 1);

        // Short line: 7 pixels plus one odd byte on line 2.
        send_frame(4, 2, 7, 1, 1'b1, -1, -1, 8'h40);
        check_counts("short", 4, 1, 0, 1, 1);

        // Overrun line: 9 pixels on line 1.
        send_frame(4, 1, 9, 0, 1'b1, -1, -1, 8'h80);
        check_counts("overrun", 4, 1, 0, 1, 1);

        // One line too many.
        send_frame(5, -1, 0, 0, 1'b1, -1, -1, 8'hC0);
        check_counts("extra_line", 5, 0, 0, 1, 1);

        // capture_en dropped mid-frame: frame completes, then idle.
        send_frame(4, -1, 0, 0, 1'b1, -1, 1, 8'h20);
        check_counts("cen_off", 4, 0, 1, 0, 2);
        check("cen_off_busy", 32'(busy_a), 0);

        send_frame(4, -1, 0, 0, 1'b0, -1, -1, 8'h30);
        check_counts("disabled", 0, 0, 0, 0, 2);

        // Single shot: only the first of three frames is captured.
        single_shot = 1'b1;
        capture_en = 1'b1;
        repeat (2) tick();
        check("single_armed_busy", 32'(busy_a), 1);
        send_frame(4, -1, 0, 0, 1'b1, -1, -1, 8'h50);
        check_counts("single_f1", 4, 0, 1, 0, 3);
        check("single_busy_a", 32'(busy_a), 0);
        check("single_busy_b", 32'(busy_b), 0);
        send_frame(4, -1, 0, 0, 1'b0, -1, -1, 8'h60);
        check_counts("single_f2", 0, 0, 0, 0, 3);
        send_frame(4, -1, 0, 0, 1'b0, -1, -1, 8'h70);
        check_counts("single_f3", 0, 0, 0, 0, 3);
        capture_en = 1'b0;
        single_shot = 1'b0;
        repeat (2) tick();

        // Reset at line 2 with capture_en held: frame discarded, next frame good.
        capture_en = 1'b1;
        repeat (2) tick();
        send_frame(4, -1, 0, 0, 1'b1, 2, -1, 8'h90);
        check_counts("rst_frame", 2, 0, 0, 0, 0);
        send_frame(4, -1, 0, 0, 1'b1, -1, -1, 8'hA0);
        check_counts("post_rst", 4, 0, 1, 0, 1);

        repeat (4) tick();
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
